// File: rtl/mult_pkg.sv
// Shared widths, iteration count and FSM state encoding for the 4-bit
// radix-2 Booth multiplier.
package mult_pkg;

    localparam int OP_W   = 4;
    localparam int PROD_W = 8;
    localparam int ITER   = 4;
    localparam int CNT_W  = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/four_bit_adder_subtractor.sv
// Four-bit two's-complement adder/subtractor.
// M=0 computes A+B, M=1 computes A-B (B inverted, carry-in set).
// C is the carry out of the MSB, V the signed overflow of the 4-bit result.
module four_bit_adder_subtractor
    import mult_pkg::*;
(
    input  logic [OP_W-1:0] A,
    input  logic [OP_W-1:0] B,
    input  logic            M,
    output logic [OP_W-1:0] S,
    output logic            C,
    output logic            V
);

    logic [OP_W-1:0] b_eff;
    logic [OP_W:0]   sum;

    // Conditional inversion of B plus carry-in gives add or subtract.
    always_comb begin
        b_eff = B ^ {OP_W{M}};
        sum   = {1'b0, A} + {1'b0, b_eff} + {{OP_W{1'b0}}, M};
        S     = sum[OP_W-1:0];
        C     = sum[OP_W];
        V     = (A[OP_W-1] == b_eff[OP_W-1]) && (sum[OP_W-1] != A[OP_W-1]);
    end

endmodule

// File: rtl/booth_multiplier_4bit.sv
// Sequential 4x4 signed radix-2 Booth multiplier.
// One Booth step per clock in CALC; the product register holds its value
// from the done pulse until the next accepted start.
// Optional build macro MULT_FLAGS_EN adds registered zero/neg flag outputs.
//
//   state | meaning
//   IDLE  | waiting for start, operands latched on acceptance
//   CALC  | four Booth add/sub + arithmetic-shift iterations
//   DONE  | product valid, done high for this single cycle
module booth_multiplier_4bit
    import mult_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [OP_W-1:0]   multiplicand,
    input  logic [OP_W-1:0]   multiplier,
    output logic              busy,
    output logic              done,
    output logic [PROD_W-1:0] product
`ifdef MULT_FLAGS_EN
    ,
    output logic              zero,
    output logic              neg
`endif
);

    state_t            state;
    state_t            state_next;

    logic [OP_W-1:0]   m_reg;
    logic [OP_W-1:0]   a_reg;
    logic [OP_W-1:0]   q_reg;
    logic              q_m1;
    logic [CNT_W-1:0]  cnt;

    logic              accept;
    logic              last_step;
    logic              do_arith;
    logic              op_sub;
    logic [OP_W-1:0]   as_sum;
    logic              as_ovf;
    logic              unused_carry;
    logic [OP_W-1:0]   a_pre;
    logic              sign_in;
    logic [OP_W-1:0]   a_shift;
    logic [OP_W-1:0]   q_shift;

    four_bit_adder_subtractor u_addsub (
        .A (a_reg),
        .B (m_reg),
        .M (op_sub),
        .S (as_sum),
        .C (unused_carry),
        .V (as_ovf)
    );

    // Booth recoding of {Q0,q_m1} and the arithmetic right shift of {A,Q,q_m1}.
    always_comb begin
        accept    = (state == IDLE) && start;
        last_step = (state == CALC) && (cnt == CNT_W'(ITER - 1));
        op_sub    = (q_reg[0] == 1'b1) && (q_m1 == 1'b0);
        do_arith  = q_reg[0] ^ q_m1;
        a_pre     = do_arith ? as_sum : a_reg;
        // The true sign of the 5-bit add/sub result is S[3]^V; using it keeps
        // the -8 multiplicand case exact.
        sign_in   = do_arith ? (as_sum[OP_W-1] ^ as_ovf) : a_reg[OP_W-1];
        a_shift   = {sign_in, a_pre[OP_W-1:1]};
        q_shift   = {a_pre[0], q_reg[OP_W-1:1]};
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    // Next-state logic.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (last_step) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Moore outputs decoded from the registered state.
    always_comb begin
        busy = (state == CALC) || (state == DONE);
        done = (state == DONE);
    end

    // Operand load on acceptance, one Booth step per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_reg <= '0;
            a_reg <= '0;
            q_reg <= '0;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (accept) begin
            m_reg <= multiplicand;
            a_reg <= '0;
            q_reg <= multiplier;
            q_m1  <= 1'b0;
            cnt   <= '0;
        end else if (state == CALC) begin
            a_reg <= a_shift;
            q_reg <= q_shift;
            q_m1  <= q_reg[0];
            cnt   <= cnt + 1'b1;
        end
    end

    // Product captured from the post-shift value of the final iteration.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         product <= '0;
        else if (last_step) product <= {a_shift, q_shift};
    end

`ifdef MULT_FLAGS_EN
    // Flags registered alongside the product.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            zero <= 1'b0;
            neg  <= 1'b0;
        end else if (last_step) begin
            zero <= ({a_shift, q_shift} == '0);
            neg  <= a_shift[OP_W-1];
        end
    end
`endif

endmodule

// File: tb/tb_booth_multiplier_4bit.sv
// Self-checking bench for booth_multiplier_4bit; reference products come from
// plain signed integer multiplication. Flag checks follow MULT_FLAGS_EN.
module tb_booth_multiplier_4bit;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic [3:0] multiplicand = '0;
    logic [3:0] multiplier = '0;
    logic       busy;
    logic       done;
    logic [7:0] product;
`ifdef MULT_FLAGS_EN
    logic       zero;
    logic       neg;
`endif

    int vecs = 0;
    int miscmp = 0;
    int done_cnt = 0;
    int start_cnt = 0;

    booth_multiplier_4bit dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .busy         (busy),
        .done         (done),
        .product      (product)
`ifdef MULT_FLAGS_EN
        ,
        .zero         (zero),
        .neg          (neg)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    function automatic logic [7:0] ref_prod(input logic [3:0] a, input logic [3:0] b);
        int ia;
        int ib;
        int p;
        ia = int'($signed(a));
        ib = int'($signed(b));
        p  = ia * ib;
        return p[7:0];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vecs++;
        assert (obs === exp) else begin
            miscmp++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One operation; spur >= 0 re-pulses start with other operands when the
    // cycle counter since acceptance equals spur (lands on a CALC edge).
    task automatic run_op(input logic [3:0] a, input logic [3:0] b,
                          input int spur, input logic [3:0] sa, input logic [3:0] sb,
                          input string tag, input bit full);
        logic [7:0] exp;
        int lat;
        exp = ref_prod(a, b);
        multiplicand = a;
        multiplier   = b;
        start        = 1'b1;
        start_cnt++;
        tick();
        start        = 1'b0;
        multiplicand = 4'($urandom);
        multiplier   = 4'($urandom);
        if (full) begin
            chk({tag, "_busy_after_accept"}, {7'd0, busy}, 8'd1);
            chk({tag, "_done_low_calc"}, {7'd0, done}, 8'd0);
        end
        lat = 0;
        while (done !== 1'b1 && lat < 12) begin
            if (lat == spur) begin
                start        = 1'b1;
                multiplicand = sa;
                multiplier   = sb;
            end
            tick();
            start = 1'b0;
            lat++;
        end
        chk({tag, "_latency"}, 8'(lat), 8'd4);
        chk({tag, "_product"}, product, exp);
`ifdef MULT_FLAGS_EN
        chk({tag, "_zero"}, {7'd0, zero}, {7'd0, exp == 8'd0});
        chk({tag, "_neg"}, {7'd0, neg}, {7'd0, exp[7]});
`endif
        if (full) chk({tag, "_busy_in_done"}, {7'd0, busy}, 8'd1);
        tick();
        chk({tag, "_busy_fall"}, {7'd0, busy}, 8'd0);
        if (full) begin
            chk({tag, "_done_single"}, {7'd0, done}, 8'd0);
            chk({tag, "_product_hold"}, product, exp);
        end
        if (spur >= 0) begin
            tick();
            chk({tag, "_no_queued_start"}, {7'd0, busy}, 8'd0);
            chk({tag, "_product_kept"}, product, exp);
        end
    endtask

    initial begin
        int d0;
        logic [3:0] ra;
        logic [3:0] rb;

        // Reset state.
        #2;
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_done", {7'd0, done}, 8'd0);
        chk("reset_product", product, 8'h00);
`ifdef MULT_FLAGS_EN
        chk("reset_zero", {7'd0, zero}, 8'd0);
        chk("reset_neg", {7'd0, neg}, 8'd0);
`endif
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Directed scenarios.
        run_op(4'd3, 4'd5, -1, 4'd0, 4'd0, "3x5", 1'b1);
        chk("3x5_const", product, 8'h0F);
        run_op(4'b1000, 4'b1000, -1, 4'd0, 4'd0, "m8xm8", 1'b1);
        chk("m8xm8_const", product, 8'h40);
        run_op(4'd7, 4'b1000, -1, 4'd0, 4'd0, "7xm8", 1'b1);
        chk("7xm8_const", product, 8'hC8);
        run_op(4'hF, 4'hF, -1, 4'd0, 4'd0, "m1xm1", 1'b1);
        chk("m1xm1_const", product, 8'h01);
        run_op(4'd0, 4'hB, -1, 4'd0, 4'd0, "0xm5", 1'b1);
        chk("0xm5_const", product, 8'h00);

        // Start re-pulsed two cycles after acceptance must be ignored.
        d0 = done_cnt;
        run_op(4'd2, 4'd3, 1, 4'd7, 4'd7, "ignore_restart", 1'b1);
        chk("ignore_restart_const", product, 8'h06);
        chk("ignore_restart_done_count", 8'(done_cnt - d0), 8'd1);

        // Reset two edges into a calculation aborts it.
        d0 = done_cnt;
        multiplicand = 4'd5;
        multiplier   = 4'd6;
        start        = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        chk("abort_busy", {7'd0, busy}, 8'd0);
        chk("abort_done", {7'd0, done}, 8'd0);
        chk("abort_product", product, 8'h00);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        chk("abort_no_done", 8'(done_cnt - d0), 8'd0);
        chk("abort_idle", {7'd0, busy}, 8'd0);
        run_op(4'hD, 4'd4, -1, 4'd0, 4'd0, "after_abort", 1'b1);
        chk("after_abort_const", product, 8'hF4);

        // Randomized operations with random ignored re-starts.
        for (int i = 0; i < 40; i++) begin
            ra = 4'($urandom);
            rb = 4'($urandom);
            run_op(ra, rb, (($urandom & 1) != 0) ? int'($urandom_range(0, 3)) : -1,
                   4'($urandom), 4'($urandom), "random", 1'b1);
            for (int g = int'($urandom_range(0, 2)); g > 0; g--) tick();
        end

        // Exhaustive sweep, each start issued right after busy falls.
        d0 = done_cnt;
        start_cnt = 0;
        for (int i = 0; i < 256; i++) begin
            ra = 4'(i >> 4);
            rb = 4'(i);
            run_op(ra, rb, -1, 4'd0, 4'd0, "sweep", 1'b0);
        end
        chk("sweep_done_count", 8'(done_cnt - d0), 8'(start_cnt));
        chk("sweep_done_count_hi", 8'((done_cnt - d0) >> 8), 8'(start_cnt >> 8));

        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscmp);
        $finish;
    end

endmodule
